// File: rtl/write_back_stage_pkg.sv
//------------------------------------------------------------------------------
// write_back_stage_pkg : default parameters and helpers for the write-back stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package write_back_stage_pkg;

    // Buffer entries are packed as {we, rd, data}
    localparam int DEF_DW       = 8;
    localparam int DEF_AW       = 3;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_CW       = 16;
    localparam int DEF_ZERO_REG = 1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
//------------------------------------------------------------------------------
// wb_fifo : circular buffer of retiring ops, entries exposed oldest-first
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_fifo
    import write_back_stage_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     push_we,
    input  logic [AW-1:0]            push_rd,
    input  logic [DW-1:0]            push_data,
    output logic                     full,
    output logic                     head_valid,
    output logic                     head_we,
    output logic [AW-1:0]            head_rd,
    output logic [DW-1:0]            head_data,
    output logic [DEPTH-1:0]         vis_valid,
    output logic [DEPTH-1:0]         vis_we,
    output logic [DEPTH-1:0][AW-1:0] vis_rd,
    output logic [DEPTH-1:0][DW-1:0] vis_data
);

    localparam int PW = ptr_w(DEPTH);
    localparam int EW = 1 + AW + DW;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= {push_we, push_rd, push_data};
    end

    assign full       = (r_count == (PW+1)'(DEPTH));
    assign head_valid = (r_count != '0);
    assign {head_we, head_rd, head_data} = r_mem[r_rd_ptr];

    // Slot i is the i-th oldest entry; higher i means younger
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx          = r_rd_ptr + PW'(i);
            vis_valid[i] = ((PW+1)'(i) < r_count);
            {vis_we[i], vis_rd[i], vis_data[i]} = r_mem[idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/write_back_stage.sv
//------------------------------------------------------------------------------
// write_back_stage : result select, stall buffer, RF write port and forwarding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CW       = DEF_CW,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dm_valid,
    output logic          dm_ready,
    input  logic          dm_sel_mem,
    input  logic [DW-1:0] dm_alu,
    input  logic [DW-1:0] dm_mem,
    input  logic [AW-1:0] dm_rd,
    input  logic          dm_we,
    input  logic          flush,
    input  logic          rf_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    output logic [DW-1:0] ans_wb,
    input  logic [AW-1:0] src_rd,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic [CW-1:0] retire_cnt
);

    localparam bit C_DROP_ZERO = (ZERO_REG != 0);

    logic                     w_full;
    logic                     w_head_valid;
    logic                     w_head_we;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_store_we;
    logic [DW-1:0]            w_result;
    logic [DEPTH-1:0]         w_vis_valid;
    logic [DEPTH-1:0]         w_vis_we;
    logic [DEPTH-1:0][AW-1:0] w_vis_rd;
    logic [DEPTH-1:0][DW-1:0] w_vis_data;
    logic [DW-1:0]            r_ans_wb;
    logic [CW-1:0]            r_retire_cnt;

    assign w_result   = dm_sel_mem ? dm_mem : dm_alu;
    assign w_store_we = dm_we & ~(C_DROP_ZERO & (dm_rd == '0));
    assign dm_ready   = ~w_full;
    assign w_push     = dm_valid & ~w_full & ~flush;
    // Non-writing ops retire without waiting for the RF port
    assign w_pop      = w_head_valid & ~flush & (rf_ready | ~w_head_we);
    assign rf_we      = w_head_valid & w_head_we & ~flush;

    wb_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (flush),
        .push_we    (w_store_we),
        .push_rd    (dm_rd),
        .push_data  (w_result),
        .full       (w_full),
        .head_valid (w_head_valid),
        .head_we    (w_head_we),
        .head_rd    (rf_addr),
        .head_data  (rf_data),
        .vis_valid  (w_vis_valid),
        .vis_we     (w_vis_we),
        .vis_rd     (w_vis_rd),
        .vis_data   (w_vis_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ans_wb     <= '0;
            r_retire_cnt <= '0;
        end else if (w_pop) begin
            if (w_head_we) r_ans_wb <= rf_data;
            r_retire_cnt <= r_retire_cnt + CW'(1);
        end
    end

    assign ans_wb     = r_ans_wb;
    assign retire_cnt = r_retire_cnt;

    // Scan oldest to youngest so the youngest match overrides
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vis_valid[i] && w_vis_we[i] && (w_vis_rd[i] == src_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_vis_data[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_write_back_stage.sv
//------------------------------------------------------------------------------
// tb_write_back_stage : directed vector table plus randomized queue-model check
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_write_back_stage;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dm_valid = 1'b0;
    logic          dm_ready;
    logic          dm_sel_mem = 1'b0;
    logic [DW-1:0] dm_alu = '0;
    logic [DW-1:0] dm_mem = '0;
    logic [AW-1:0] dm_rd = '0;
    logic          dm_we = 1'b0;
    logic          flush = 1'b0;
    logic          rf_ready = 1'b0;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [DW-1:0] ans_wb;
    logic [AW-1:0] src_rd = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] retire_cnt;

    write_back_stage #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset), .dm_valid(dm_valid), .dm_ready(dm_ready),
        .dm_sel_mem(dm_sel_mem), .dm_alu(dm_alu), .dm_mem(dm_mem), .dm_rd(dm_rd),
        .dm_we(dm_we), .flush(flush), .rf_ready(rf_ready), .rf_we(rf_we),
        .rf_addr(rf_addr), .rf_data(rf_data), .ans_wb(ans_wb), .src_rd(src_rd),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input int rst, input int v, input int sm, input int alu, input int mem,
                         input int rd, input int we, input int fl, input int rr, input int src);
        reset      = 1'(rst);
        dm_valid   = 1'(v);
        dm_sel_mem = 1'(sm);
        dm_alu     = DW'(alu);
        dm_mem     = DW'(mem);
        dm_rd      = AW'(rd);
        dm_we      = 1'(we);
        flush      = 1'(fl);
        rf_ready   = 1'(rr);
        src_rd     = AW'(src);
    endtask

    // Directed vectors: inputs applied for one cycle, outputs expected before the edge
    typedef struct {
        int rst, v, sm, alu, mem, rd, we, fl, rr, src;
        int e_rdy, e_rwe, e_chkh, e_addr, e_data, e_ans, e_cnt, e_hit, e_fd;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input int rst, input int v, input int sm, input int alu,
                                input int mem, input int rd, input int we, input int fl,
                                input int rr, input int src, input int e_rdy, input int e_rwe,
                                input int e_chkh, input int e_addr, input int e_data,
                                input int e_ans, input int e_cnt, input int e_hit, input int e_fd);
        vec_t t;
        t.rst = rst; t.v = v; t.sm = sm; t.alu = alu; t.mem = mem; t.rd = rd; t.we = we;
        t.fl = fl; t.rr = rr; t.src = src; t.e_rdy = e_rdy; t.e_rwe = e_rwe; t.e_chkh = e_chkh;
        t.e_addr = e_addr; t.e_data = e_data; t.e_ans = e_ans; t.e_cnt = e_cnt;
        t.e_hit = e_hit; t.e_fd = e_fd;
        return t;
    endfunction

    // Behavioural reference: a queue of {we, rd, data} records
    typedef struct {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] m_ans;
    logic [CW-1:0] m_cnt;

    task automatic model_check();
        logic          e_hit;
        logic [DW-1:0] e_fd;
        logic          hv;
        hv    = (mq.size() > 0);
        e_hit = 1'b0;
        e_fd  = '0;
        foreach (mq[k]) begin
            if (mq[k].we && mq[k].rd == src_rd) begin
                e_hit = 1'b1;
                e_fd  = mq[k].d;
            end
        end
        chk("rnd_dm_ready", 32'(dm_ready), 32'(mq.size() < DEPTH));
        chk("rnd_rf_we", 32'(rf_we), 32'(hv && mq[0].we && !flush));
        if (hv) begin
            chk("rnd_rf_addr", 32'(rf_addr), 32'(mq[0].rd));
            chk("rnd_rf_data", 32'(rf_data), 32'(mq[0].d));
        end
        chk("rnd_ans_wb", 32'(ans_wb), 32'(m_ans));
        chk("rnd_retire_cnt", 32'(retire_cnt), 32'(m_cnt));
        chk("rnd_fwd_hit", 32'(fwd_hit), 32'(e_hit));
        chk("rnd_fwd_data", 32'(fwd_data), 32'(e_fd));
    endtask

    task automatic model_step();
        ent_t e;
        bit   was_full;
        if (reset) begin
            mq.delete();
            m_ans = '0;
            m_cnt = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && (rf_ready || !mq[0].we)) begin
                if (mq[0].we) m_ans = mq[0].d;
                m_cnt = m_cnt + 1'b1;
                void'(mq.pop_front());
            end
            if (dm_valid && !was_full) begin
                e.we = dm_we && (dm_rd != 0);
                e.rd = dm_rd;
                e.d  = dm_sel_mem ? dm_mem : dm_alu;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst v sm alu   mem   rd we fl rr src | rdy rwe ch addr data  ans   cnt hit fd
        tbl[0]  = mk(1, 1, 0, 'h55, 'h00, 3, 1, 0, 1, 0,   1, 0, 0, 0, 'h00, 'h00, 0, 0, 'h00);
        tbl[1]  = mk(1, 1, 0, 'h55, 'h00, 3, 1, 0, 1, 0,   1, 0, 0, 0, 'h00, 'h00, 0, 0, 'h00);
        tbl[2]  = mk(0, 1, 0, 'h0F, 'h33, 3, 1, 0, 1, 3,   1, 0, 0, 0, 'h00, 'h00, 0, 0, 'h00);
        tbl[3]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 3,   1, 1, 1, 3, 'h0F, 'h00, 0, 1, 'h0F);
        tbl[4]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 3,   1, 0, 0, 0, 'h00, 'h0F, 1, 0, 'h00);
        tbl[5]  = mk(0, 1, 1, 'h00, 'hFF, 1, 1, 0, 0, 0,   1, 0, 0, 0, 'h00, 'h0F, 1, 0, 'h00);
        tbl[6]  = mk(0, 1, 0, 'hAA, 'h00, 2, 1, 0, 0, 1,   1, 1, 1, 1, 'hFF, 'h0F, 1, 1, 'hFF);
        tbl[7]  = mk(0, 1, 0, 'hBB, 'h00, 7, 1, 0, 0, 2,   0, 1, 1, 1, 'hFF, 'h0F, 1, 1, 'hAA);
        tbl[8]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 2,   0, 1, 1, 1, 'hFF, 'h0F, 1, 1, 'hAA);
        tbl[9]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 2,   1, 1, 1, 2, 'hAA, 'hFF, 2, 1, 'hAA);
        tbl[10] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 2,   1, 0, 0, 0, 'h00, 'hAA, 3, 0, 'h00);
        tbl[11] = mk(0, 1, 0, 'h11, 'h00, 5, 1, 0, 0, 5,   1, 0, 0, 0, 'h00, 'hAA, 3, 0, 'h00);
        tbl[12] = mk(0, 1, 0, 'h22, 'h00, 5, 1, 0, 0, 5,   1, 1, 1, 5, 'h11, 'hAA, 3, 1, 'h11);
        tbl[13] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 5,   0, 1, 1, 5, 'h11, 'hAA, 3, 1, 'h22);
        tbl[14] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 6,   0, 1, 1, 5, 'h11, 'hAA, 3, 0, 'h00);
        tbl[15] = mk(0, 1, 0, 'h77, 'h00, 4, 1, 1, 1, 5,   0, 0, 1, 5, 'h11, 'hAA, 3, 1, 'h22);
        tbl[16] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 5,   1, 0, 0, 0, 'h00, 'hAA, 3, 0, 'h00);
        tbl[17] = mk(0, 1, 0, 'h99, 'h00, 0, 1, 0, 1, 0,   1, 0, 0, 0, 'h00, 'hAA, 3, 0, 'h00);
        tbl[18] = mk(0, 1, 0, 'h44, 'h00, 4, 0, 0, 1, 0,   1, 0, 1, 0, 'h99, 'hAA, 3, 0, 'h00);
        tbl[19] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 4,   1, 0, 1, 4, 'h44, 'hAA, 4, 0, 'h00);
        tbl[20] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 4,   1, 0, 0, 0, 'h00, 'hAA, 5, 0, 'h00);
        tbl[21] = mk(0, 1, 0, 'h5A, 'h00, 6, 1, 0, 0, 6,   1, 0, 0, 0, 'h00, 'hAA, 5, 0, 'h00);
        tbl[22] = mk(0, 1, 0, 'h6B, 'h00, 6, 1, 1, 1, 6,   1, 0, 1, 6, 'h5A, 'hAA, 5, 1, 'h5A);
        tbl[23] = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 1, 6,   1, 0, 0, 0, 'h00, 'hAA, 5, 0, 'h00);

        drive(1, 1, 0, 'h55, 0, 3, 1, 0, 1, 0);
        @(posedge clk);

        foreach (tbl[r]) begin
            @(negedge clk);
            drive(tbl[r].rst, tbl[r].v, tbl[r].sm, tbl[r].alu, tbl[r].mem, tbl[r].rd,
                  tbl[r].we, tbl[r].fl, tbl[r].rr, tbl[r].src);
            #1;
            chk($sformatf("vec%0d_dm_ready", r), 32'(dm_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("vec%0d_rf_we", r), 32'(rf_we), 32'(tbl[r].e_rwe));
            if (tbl[r].e_chkh != 0) begin
                chk($sformatf("vec%0d_rf_addr", r), 32'(rf_addr), 32'(tbl[r].e_addr));
                chk($sformatf("vec%0d_rf_data", r), 32'(rf_data), 32'(tbl[r].e_data));
            end
            chk($sformatf("vec%0d_ans_wb", r), 32'(ans_wb), 32'(tbl[r].e_ans));
            chk($sformatf("vec%0d_retire_cnt", r), 32'(retire_cnt), 32'(tbl[r].e_cnt));
            chk($sformatf("vec%0d_fwd_hit", r), 32'(fwd_hit), 32'(tbl[r].e_hit));
            chk($sformatf("vec%0d_fwd_data", r), 32'(fwd_data), 32'(tbl[r].e_fd));
        end

        // Reset in the middle of a stall discards the buffered ops
        @(negedge clk); drive(0, 1, 0, 'hC3, 0, 2, 1, 0, 0, 2);
        @(negedge clk); drive(0, 1, 0, 'hD4, 0, 3, 1, 0, 0, 2);
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        #1;
        chk("stall_full_ready", 32'(dm_ready), 32'h0);
        chk("stall_rf_data", 32'(rf_data), 32'hC3);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        #1;
        chk("rst_stall_rf_we", 32'(rf_we), 32'h0);
        chk("rst_stall_ready", 32'(dm_ready), 32'h1);
        chk("rst_stall_ans", 32'(ans_wb), 32'h0);
        chk("rst_stall_cnt", 32'(retire_cnt), 32'h0);
        chk("rst_stall_fwd", 32'(fwd_hit), 32'h0);

        // Randomized traffic against the queue model; first cycle resyncs via reset
        m_ans = '0;
        m_cnt = '0;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            drive((c == 0 || $urandom_range(0, 99) < 2) ? 1 : 0,
                  ($urandom_range(0, 9) < 7) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 8) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)));
            #1;
            if (c > 0) model_check();
            model_step();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
